// File: rtl/pifo_sched_ctrl.sv
// pifo_sched_ctrl: shares one pifo_reg between N_PORTS round-robin enqueue requesters and a
// single dequeue client; counts committed plus staged entries so the PIFO never overflows.
module pifo_sched_ctrl #(
    parameter int N_PORTS     = 4,
    parameter int L2_MAX_SIZE = 3,
    parameter int RANK_WIDTH  = 8,
    parameter int META_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            in_valid,
    output logic [N_PORTS-1:0]            in_ready,
    input  logic [N_PORTS*RANK_WIDTH-1:0] in_rank,
    input  logic [N_PORTS*META_WIDTH-1:0] in_meta,
    input  logic                          out_req,
    output logic                          out_valid,
    output logic [RANK_WIDTH-1:0]         out_rank,
    output logic [META_WIDTH-1:0]         out_meta,
    output logic [L2_MAX_SIZE:0]          occupancy,
    output logic                          full,
    output logic                          err_underflow,
    output logic                          pifo_insert,
    output logic                          pifo_remove,
    output logic [RANK_WIDTH-1:0]         pifo_rank_in,
    output logic [META_WIDTH-1:0]         pifo_meta_in,
    input  logic [RANK_WIDTH-1:0]         pifo_rank_out,
    input  logic [META_WIDTH-1:0]         pifo_meta_out,
    input  logic                          pifo_valid_out
);
    localparam int                   PTR_W       = $clog2(N_PORTS);
    localparam logic [PTR_W:0]       NUM_PORTS   = (PTR_W + 1)'(N_PORTS);
    localparam logic [L2_MAX_SIZE:0] MAX_ENTRIES = (L2_MAX_SIZE + 1)'(1) << L2_MAX_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        SETTLE
    } state_t;

    state_t                 state;
    logic                   pend;
    logic [PTR_W-1:0]       rr_ptr;
    logic [L2_MAX_SIZE:0]   resv;
    logic                   space_ok;
    logic                   grant_found;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W:0]         cand;
    logic [RANK_WIDTH-1:0]  grant_rank;
    logic [META_WIDTH-1:0]  grant_meta;
    logic                   transfer;

    // The staged entry is already promised a slot, so it counts against capacity.
    assign resv     = occupancy + {{L2_MAX_SIZE{1'b0}}, pifo_insert};
    assign space_ok = (resv != MAX_ENTRIES) || pifo_remove;
    assign full     = (resv == MAX_ENTRIES);

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!grant_found && in_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        grant_rank = '0;
        grant_meta = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (grant_idx == PTR_W'(k)) begin
                grant_rank = in_rank[k*RANK_WIDTH +: RANK_WIDTH];
                grant_meta = in_meta[k*META_WIDTH +: META_WIDTH];
            end
        end
    end

    assign transfer = grant_found && space_ok;
    assign in_ready = transfer ? (N_PORTS'(1) << grant_idx) : '0;

    // Insert stage and committed-entry counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            pifo_insert  <= 1'b0;
            pifo_rank_in <= '0;
            pifo_meta_in <= '0;
            occupancy    <= '0;
        end else begin
            // NOTE: state updates are non-blocking so every block samples pre-edge values.
            pifo_insert <= transfer;
            if (transfer) begin
                rr_ptr       <= (grant_idx == PTR_W'(N_PORTS - 1)) ? '0 : grant_idx + PTR_W'(1);
                pifo_rank_in <= grant_rank;
                pifo_meta_in <= grant_meta;
            end
            case ({pifo_insert, pifo_remove})
                2'b10:   occupancy <= occupancy + (L2_MAX_SIZE + 1)'(1);
                2'b01:   occupancy <= occupancy - (L2_MAX_SIZE + 1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Dequeue sequencer: POP removes the head, SETTLE lets pifo_reg present the next head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pend          <= 1'b0;
            pifo_remove   <= 1'b0;
            out_valid     <= 1'b0;
            out_rank      <= '0;
            out_meta      <= '0;
            err_underflow <= 1'b0;
        end else begin
            pifo_remove <= 1'b0;
            out_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if ((pend || out_req) && (occupancy != '0)) begin
                        state       <= POP;
                        pifo_remove <= 1'b1;
                        pend        <= 1'b0;
                    end else if (out_req) begin
                        pend <= 1'b1;
                    end
                end
                POP: begin
                    state     <= SETTLE;
                    out_valid <= 1'b1;
                    out_rank  <= pifo_rank_out;
                    out_meta  <= pifo_meta_out;
                    if (!pifo_valid_out) begin
                        err_underflow <= 1'b1;
                    end
                    if (out_req) begin
                        pend <= 1'b1;
                    end
                end
                SETTLE: begin
                    state <= IDLE;
                    if (out_req) begin
                        pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pifo_sched_ctrl.sv
// tb_pifo_sched_ctrl: self-checking bench for pifo_sched_ctrl with a behavioural pifo_reg
// (sorted, capacity 8, equal ranks kept in arrival order) attached to its pifo_* ports.
module tb_pifo_sched_ctrl;
    typedef struct packed {
        logic [7:0] rank;
        logic [7:0] meta;
    } entry_t;

    typedef struct {
        bit         rst_before;
        logic [3:0] valid;
        logic [3:0] ready;
        logic       full;
        logic [3:0] occ;
    } arb_vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_rank;
    logic [31:0] in_meta;
    logic        out_req;
    logic        out_valid;
    logic [7:0]  out_rank;
    logic [7:0]  out_meta;
    logic [3:0]  occupancy;
    logic        full;
    logic        err_underflow;
    logic        pifo_insert;
    logic        pifo_remove;
    logic [7:0]  pifo_rank_in;
    logic [7:0]  pifo_meta_in;
    logic [7:0]  pifo_rank_out;
    logic [7:0]  pifo_meta_out;
    logic        pifo_valid_out;

    int checks = 0;
    int failures = 0;
    int ov_count = 0;
    int rm_count = 0;

    entry_t exp_q[$];
    entry_t pq[$];
    entry_t head;
    logic   head_valid;
    logic   model_overflow;
    int     ins_pos;

    logic [44:0] all_outputs;
    assign all_outputs = {in_ready, out_valid, out_rank, out_meta, occupancy, full, err_underflow,
                          pifo_insert, pifo_remove, pifo_rank_in, pifo_meta_in};

    pifo_sched_ctrl #(
        .N_PORTS(4),
        .L2_MAX_SIZE(3),
        .RANK_WIDTH(8),
        .META_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_rank(in_rank),
        .in_meta(in_meta),
        .out_req(out_req),
        .out_valid(out_valid),
        .out_rank(out_rank),
        .out_meta(out_meta),
        .occupancy(occupancy),
        .full(full),
        .err_underflow(err_underflow),
        .pifo_insert(pifo_insert),
        .pifo_remove(pifo_remove),
        .pifo_rank_in(pifo_rank_in),
        .pifo_meta_in(pifo_meta_in),
        .pifo_rank_out(pifo_rank_out),
        .pifo_meta_out(pifo_meta_out),
        .pifo_valid_out(pifo_valid_out)
    );

    always #5 clk = ~clk;

    // Behavioural pifo_reg: remove takes the pre-insert head, insert goes after equal ranks.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pq.delete();
            head           <= '0;
            head_valid     <= 1'b0;
            model_overflow <= 1'b0;
        end else begin
            if (pifo_remove && pq.size() > 0) begin
                void'(pq.pop_front());
            end
            if (pifo_insert) begin
                ins_pos = pq.size();
                for (int i = pq.size() - 1; i >= 0; i--) begin
                    if (pq[i].rank > pifo_rank_in) ins_pos = i;
                end
                pq.insert(ins_pos, entry_t'({pifo_rank_in, pifo_meta_in}));
            end
            if (pq.size() > 8) model_overflow <= 1'b1;
            head       <= (pq.size() > 0) ? pq[0] : '0;
            head_valid <= (pq.size() > 0);
        end
    end

    assign pifo_rank_out  = head.rank;
    assign pifo_meta_out  = head.meta;
    assign pifo_valid_out = head_valid;

    always @(negedge clk) begin
        if (out_valid) ov_count++;
        if (pifo_remove) rm_count++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = '0;
        out_req  = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input int p, input logic [7:0] r, input logic [7:0] m);
        bit ok;
        ok = 1'b0;
        in_rank[p*8 +: 8] = r;
        in_meta[p*8 +: 8] = m;
        in_valid[p]       = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready[p];
            @(posedge clk);
            #1;
        end
        in_valid[p] = 1'b0;
        check($sformatf("accept_port%0d_rank%0d", p, r), 64'(ok), 64'(1));
    endtask

    task automatic pulse_req();
        out_req = 1'b1;
        @(posedge clk);
        #1;
        out_req = 1'b0;
    endtask

    task automatic request(input logic [7:0] r, input logic [7:0] m);
        exp_q.push_back(entry_t'({r, m}));
        pulse_req();
    endtask

    task automatic collect(input int budget, output int waited);
        bit     seen;
        entry_t e;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < budget) begin
            @(negedge clk);
            waited++;
            seen = out_valid;
        end
        check("out_valid_seen", 64'(seen), 64'(1));
        if (seen) begin
            check("sb_pending", 64'(exp_q.size()), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_rank", 64'(out_rank), 64'(e.rank));
                check("out_meta", 64'(out_meta), 64'(e.meta));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arb_vec_t   vecs[21];
        logic [7:0] t4_rank[8];
        logic [7:0] t4_exp_rank[8];
        logic [7:0] t4_exp_meta[8];
        int         n;
        int         ov_before;
        int         rm_before;

        // Rows 0-10: skipping idle ports and wrap-around; rows 11-20: all ports busy until full.
        vecs[0]  = '{1'b1, 4'b0101, 4'b0001, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 4'b0101, 4'b0100, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 4'b0011, 4'b0001, 1'b0, 4'd1};
        vecs[3]  = '{1'b0, 4'b1000, 4'b1000, 1'b0, 4'd2};
        vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'd3};
        vecs[5]  = '{1'b0, 4'b0110, 4'b0010, 1'b0, 4'd4};
        vecs[6]  = '{1'b0, 4'b1111, 4'b0100, 1'b0, 4'd4};
        vecs[7]  = '{1'b0, 4'b1111, 4'b1000, 1'b0, 4'd5};
        vecs[8]  = '{1'b0, 4'b1111, 4'b0001, 1'b0, 4'd6};
        vecs[9]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'd7};
        vecs[10] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'd8};
        vecs[11] = '{1'b1, 4'b1111, 4'b0001, 1'b0, 4'd0};
        vecs[12] = '{1'b0, 4'b1111, 4'b0010, 1'b0, 4'd0};
        vecs[13] = '{1'b0, 4'b1111, 4'b0100, 1'b0, 4'd1};
        vecs[14] = '{1'b0, 4'b1111, 4'b1000, 1'b0, 4'd2};
        vecs[15] = '{1'b0, 4'b1111, 4'b0001, 1'b0, 4'd3};
        vecs[16] = '{1'b0, 4'b1111, 4'b0010, 1'b0, 4'd4};
        vecs[17] = '{1'b0, 4'b1111, 4'b0100, 1'b0, 4'd5};
        vecs[18] = '{1'b0, 4'b1111, 4'b1000, 1'b0, 4'd6};
        vecs[19] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'd7};
        vecs[20] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'd8};

        t4_rank     = '{8'd8, 8'd87, 8'd54, 8'd76, 8'd47, 8'd68, 8'd29, 8'd98};
        t4_exp_rank = '{8'd8, 8'd29, 8'd47, 8'd54, 8'd68, 8'd76, 8'd87, 8'd98};
        t4_exp_meta = '{8'h20, 8'h80, 8'h60, 8'h40, 8'h70, 8'h50, 8'h30, 8'h90};

        rst_n    = 1'b0;
        in_valid = '0;
        in_rank  = '0;
        in_meta  = '0;
        out_req  = 1'b0;
        @(negedge clk);
        check("reset_outputs_zero", 64'(all_outputs), 64'(0));
        step(1);
        rst_n = 1'b1;

        // Single insert then single dequeue.
        send(0, 8'd5, 8'h10);
        @(negedge clk);
        check("t1_pifo_insert", 64'(pifo_insert), 64'(1));
        check("t1_pifo_rank_in", 64'(pifo_rank_in), 64'(5));
        check("t1_pifo_meta_in", 64'(pifo_meta_in), 64'(8'h10));
        check("t1_occupancy_before_commit", 64'(occupancy), 64'(0));
        step(1);
        @(negedge clk);
        check("t1_occupancy", 64'(occupancy), 64'(1));
        step(1);
        request(8'd5, 8'h10);
        collect(8, n);
        check("t1_latency", 64'(n), 64'(2));
        check("t1_occupancy_after", 64'(occupancy), 64'(0));
        step(1);

        // Arbitration tables.
        in_rank = {8'h43, 8'h42, 8'h41, 8'h40};
        in_meta = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int v = 0; v < 21; v++) begin
            if (vecs[v].rst_before) do_reset();
            in_valid = vecs[v].valid;
            @(negedge clk);
            check($sformatf("arb_ready_row%0d", v), 64'(in_ready), 64'(vecs[v].ready));
            check($sformatf("arb_full_row%0d", v), 64'(full), 64'(vecs[v].full));
            check($sformatf("arb_occ_row%0d", v), 64'(occupancy), 64'(vecs[v].occ));
            step(1);
        end

        // Full PIFO: a dequeue frees exactly one slot during POP.
        out_req = 1'b1;
        exp_q.push_back(entry_t'({8'h40, 8'hA0}));
        @(negedge clk);
        check("t3_ready_while_full", 64'(in_ready), 64'(0));
        step(1);
        out_req = 1'b0;
        @(negedge clk);
        check("t3_pop_remove", 64'(pifo_remove), 64'(1));
        check("t3_pop_ready", 64'(in_ready), 64'(4'b0001));
        step(1);
        in_valid = '0;
        collect(4, n);
        check("t3_latency", 64'(n), 64'(1));
        check("t3_full_settle", 64'(full), 64'(1));
        step(1);
        @(negedge clk);
        check("t3_occupancy", 64'(occupancy), 64'(8));
        check("t3_no_overflow", 64'(model_overflow), 64'(0));
        step(1);

        // Sorted dequeue order.
        do_reset();
        for (int i = 0; i < 8; i++) send(0, t4_rank[i], 8'h20 + 8'(i * 16));
        step(2);
        @(negedge clk);
        check("t4_occupancy_full", 64'(occupancy), 64'(8));
        check("t4_full", 64'(full), 64'(1));
        step(1);
        for (int i = 0; i < 8; i++) begin
            request(t4_exp_rank[i], t4_exp_meta[i]);
            collect(8, n);
            check($sformatf("t4_latency_%0d", i), 64'(n), 64'(2));
            step(1);
        end
        check("t4_err_underflow", 64'(err_underflow), 64'(0));
        check("t4_occupancy_empty", 64'(occupancy), 64'(0));

        // Request while empty stays pending; a second request is dropped.
        rm_before = rm_count;
        ov_before = ov_count;
        request(8'd3, 8'h33);
        step(1);
        pulse_req();
        step(4);
        check("t5_no_remove_when_empty", 64'(rm_count - rm_before), 64'(0));
        send(1, 8'd3, 8'h33);
        @(negedge clk);
        check("t5_pifo_insert", 64'(pifo_insert), 64'(1));
        collect(8, n);
        check("t5_insert_to_out_valid", 64'(n), 64'(3));
        step(8);
        check("t5_single_response", 64'(ov_count - ov_before), 64'(1));
        check("t5_occupancy", 64'(occupancy), 64'(0));

        // Reset asserted during POP.
        send(0, 8'd9, 8'h99);
        send(2, 8'd4, 8'h44);
        step(2);
        @(negedge clk);
        check("t6_occupancy_before", 64'(occupancy), 64'(2));
        step(1);
        pulse_req();
        @(negedge clk);
        check("t6_in_pop", 64'(pifo_remove), 64'(1));
        ov_before = ov_count;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_outputs_zero_in_reset", 64'(all_outputs), 64'(0));
        step(2);
        rst_n = 1'b1;
        step(5);
        @(negedge clk);
        check("t6_occupancy_after", 64'(occupancy), 64'(0));
        check("t6_no_spurious_out_valid", 64'(ov_count - ov_before), 64'(0));
        step(1);
        send(3, 8'd7, 8'h77);
        step(2);
        request(8'd7, 8'h77);
        collect(8, n);
        check("t6_recover_latency", 64'(n), 64'(2));
        step(2);

        check("final_no_overflow", 64'(model_overflow), 64'(0));
        check("final_err_underflow", 64'(err_underflow), 64'(0));
        check("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
